// File: rtl/tinyalu_pkg.sv
// Shared definitions for the TinyALU core: opcodes, FSM states and default width.
package tinyalu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/tinyalu_if.sv
// Request/response bundle between the transaction driver and the TinyALU core.
interface tinyalu_if
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  // Driver side: issues requests, observes completion.
  modport master (
    output start, op, A, B,
    input  done, result, busy
  );

  // ALU side: consumes requests, reports completion.
  modport slave (
    input  start, op, A, B,
    output done, result, busy
  );

endinterface

// File: rtl/tinyalu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
// The final product is presented combinationally in the cycle of the last
// iteration so the owner can capture it on that same edge.
module tinyalu_mul_seq
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic                 running_q, running_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   addend;

  // Partial product for the current iteration and the running sum including it.
  always_comb begin
    addend        = b[cnt_q] ? ({{WIDTH{1'b0}}, a} << cnt_q) : '0;
    product       = acc_q + addend;
    product_valid = running_q && (cnt_q == LAST_ITER);
  end

  // Iteration control: start clears the accumulator, abort drops the run.
  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    if (go) begin
      running_d = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
    end else if (running_q) begin
      if (abort) begin
        running_d = 1'b0;
        cnt_d     = '0;
        acc_d     = '0;
      end else begin
        acc_d = product;
        if (cnt_q == LAST_ITER) begin
          running_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU arithmetic/logic engine: accepts a held-high start, runs add/and/xor
// in one cycle or multiply over WIDTH cycles, pulses done once, then waits in
// RELEASE until the driver drops start so a lingering start never retriggers.
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  tinyalu_if.slave  bus
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 mul_go;
  logic                 mul_abort;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 mul_valid;

  // Single-cycle operations; reserved opcodes yield zero.
  function automatic logic [2*WIDTH-1:0] alu_result(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [2*WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = {{(WIDTH-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
      OP_AND:  res = {{WIDTH{1'b0}}, (a & b)};
      OP_XOR:  res = {{WIDTH{1'b0}}, (a ^ b)};
      default: res = '0;
    endcase
    return res;
  endfunction

  tinyalu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (mul_go),
    .abort        (mul_abort),
    .a            (a_q),
    .b            (b_q),
    .product      (mul_product),
    .product_valid(mul_valid)
  );

  // Next-state, operand latching and completion logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    mul_go    = 1'b0;
    mul_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          a_d    = bus.A;
          b_d    = bus.B;
          busy_d = 1'b1;
          case (bus.op)
            OP_NOP:  state_d = ST_RELEASE;
            OP_MUL: begin
              state_d = ST_MUL;
              mul_go  = 1'b1;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          result_d = alu_result(op_q, a_q, b_q);
          done_d   = 1'b1;
          state_d  = ST_RELEASE;
        end
      end
      ST_MUL: begin
        if (!bus.start) begin
          mul_abort = 1'b1;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end else if (mul_valid) begin
          result_d = mul_product;
          done_d   = 1'b1;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed bench for tinyalu_core: hand-computed vectors, immediate assertions.
module tb_tinyalu_core;
  import tinyalu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   done_seen;
  int   gap;

  tinyalu_if #(.WIDTH(W)) bus ();

  tinyalu_core #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which done is observed high.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = s;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    reset_n   = 1'b0;
    drive(1'b0, OP_NOP, 8'h00, 8'h00);
    step();
    step();
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_result", {16'd0, bus.result}, 32'd0);
    reset_n = 1'b1;
    step();

    // add FF+01, operands changed after acceptance, start held past done
    drive(1'b1, OP_ADD, 8'hFF, 8'h01);
    step();
    chk("add_accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("add_accept_done", {31'd0, bus.done}, 32'd0);
    drive(1'b1, OP_XOR, 8'h00, 8'h00);
    step();
    chk("add_done", {31'd0, bus.done}, 32'd1);
    chk("add_result", {16'd0, bus.result}, 32'h0100);
    step();
    chk("add_hold_done", {31'd0, bus.done}, 32'd0);
    chk("add_hold_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("add_hold2_done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    step();
    chk("add_rel_busy", {31'd0, bus.busy}, 32'd0);
    chk("add_rel_result", {16'd0, bus.result}, 32'h0100);
    chk("add_done_count", done_seen, 32'd1);

    // mul FF*FF: done exactly 8 edges after acceptance
    drive(1'b1, OP_MUL, 8'hFF, 8'hFF);
    step();
    for (int i = 1; i < W; i++) begin
      chk("mul_ff_busy", {31'd0, bus.busy}, 32'd1);
      chk("mul_ff_nodone", {31'd0, bus.done}, 32'd0);
      step();
    end
    chk("mul_ff_busy_last", {31'd0, bus.busy}, 32'd1);
    chk("mul_ff_nodone_last", {31'd0, bus.done}, 32'd0);
    step();
    chk("mul_ff_done", {31'd0, bus.done}, 32'd1);
    chk("mul_ff_result", {16'd0, bus.result}, 32'hFE01);
    chk("mul_ff_busy_done", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    step();
    chk("mul_ff_rel_done", {31'd0, bus.done}, 32'd0);
    chk("mul_ff_rel_busy", {31'd0, bus.busy}, 32'd0);

    // mul 00*37
    drive(1'b1, OP_MUL, 8'h00, 8'h37);
    for (int i = 0; i < W; i++) step();
    chk("mul_zero_nodone", {31'd0, bus.done}, 32'd0);
    step();
    chk("mul_zero_done", {31'd0, bus.done}, 32'd1);
    chk("mul_zero_result", {16'd0, bus.result}, 32'h0000);
    bus.start = 1'b0;
    step();
    chk("mul_done_count", done_seen, 32'd3);

    // xor then and with a random idle gap
    drive(1'b1, OP_XOR, 8'hA5, 8'h0F);
    step();
    step();
    chk("xor_done", {31'd0, bus.done}, 32'd1);
    chk("xor_result", {16'd0, bus.result}, 32'h00AA);
    bus.start = 1'b0;
    step();
    gap = $urandom_range(0, 3);
    for (int i = 0; i < gap; i++) step();
    drive(1'b1, OP_AND, 8'hA5, 8'h0F);
    step();
    chk("and_accept_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("and_done", {31'd0, bus.done}, 32'd1);
    chk("and_result", {16'd0, bus.result}, 32'h0005);
    bus.start = 1'b0;
    step();
    chk("logic_done_count", done_seen, 32'd5);

    // no_op: no done, result kept, back to idle when start drops
    drive(1'b1, OP_NOP, 8'h12, 8'h34);
    step();
    chk("nop_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("nop_nodone", {31'd0, bus.done}, 32'd0);
    chk("nop_result", {16'd0, bus.result}, 32'h0005);
    chk("nop_busy_held", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    step();
    chk("nop_rel_busy", {31'd0, bus.busy}, 32'd0);
    chk("nop_done_count", done_seen, 32'd5);

    // mul 10*10 aborted after iteration 3 completes
    drive(1'b1, OP_MUL, 8'h10, 8'h10);
    step();
    for (int i = 0; i < 4; i++) step();
    bus.start = 1'b0;
    step();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", {16'd0, bus.result}, 32'h0005);
    for (int i = 0; i < W; i++) step();
    chk("abort_done_count", done_seen, 32'd5);

    // reset mid-mul, with start already high for an add when reset releases
    drive(1'b1, OP_MUL, 8'h10, 8'h10);
    step();
    step();
    step();
    reset_n = 1'b0;
    drive(1'b1, OP_ADD, 8'h03, 8'h04);
    step();
    chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_result", {16'd0, bus.result}, 32'h0000);
    reset_n = 1'b1;
    step();
    chk("post_rst_accept_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("post_rst_done", {31'd0, bus.done}, 32'd1);
    chk("post_rst_result", {16'd0, bus.result}, 32'h0007);
    bus.start = 1'b0;
    step();

    // reserved opcode 110 completes with zero
    drive(1'b1, 3'b110, 8'hFF, 8'hFF);
    step();
    chk("rsv_accept_nodone", {31'd0, bus.done}, 32'd0);
    step();
    chk("rsv_done", {31'd0, bus.done}, 32'd1);
    chk("rsv_result", {16'd0, bus.result}, 32'h0000);
    bus.start = 1'b0;
    step();
    chk("rsv_rel_busy", {31'd0, bus.busy}, 32'd0);
    chk("final_done_count", done_seen, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
